nios_practica_led_fader: RTL and testbench

//  Downstream stage of the LED output PIO: takes its 8-bit out_port as per-LED on/off targets and

---
 rtl/nios_practica_led_fader.sv | 101 ++++++++++
 tb/tb_nios_practica_led_fader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/nios_practica_led_fader.sv
// PWM LED fader fed by the LED PIO: each channel ramps its brightness toward
// full-on or off according to the matching in_port bit.
module nios_practica_led_fader #(
  parameter int CHANNELS = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 50,
  parameter int FADE_DIV = 4,
  parameter int STEP     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in_port,
  input  logic                enable,
  output logic [CHANNELS-1:0] led_out,
  output logic                busy,
  output logic                period
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FD_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PWM_BITS:0]   MAX_X    = {1'b0, MAX};
  localparam logic [PWM_BITS:0]   STEP_X   = (PWM_BITS+1)'(STEP);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [FD_W-1:0]     FD_LAST  = FD_W'(FADE_DIV - 1);

  logic [PRE_W-1:0]    pre;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [FD_W-1:0]     fade_cnt;
  logic [CHANNELS-1:0] tgt;
  logic [PWM_BITS-1:0] level     [CHANNELS];
  logic [PWM_BITS-1:0] level_nxt [CHANNELS];
  logic                tick;
  logic                wrap;
  logic                step_evt;

  assign tick     = (pre == PRE_LAST);
  assign wrap     = tick && (pwm_cnt == MAX);
  assign step_evt = wrap && (fade_cnt == FD_LAST);

  // Saturating one-step move toward the target, done one bit wider so the
  // upward sum cannot wrap past full brightness.
  always_comb begin
    logic [PWM_BITS:0] sum;
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      level_nxt[i] = level[i];
      if (step_evt) begin
        if (tgt[i] && (level[i] != MAX)) begin
          sum = {1'b0, level[i]} + STEP_X;
          level_nxt[i] = (sum > MAX_X) ? MAX : sum[PWM_BITS-1:0];
        end else if (!tgt[i] && (level[i] != '0)) begin
          level_nxt[i] = ({1'b0, level[i]} > STEP_X) ?
                         (level[i] - STEP_X[PWM_BITS-1:0]) : '0;
        end
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (level[i] != (tgt[i] ? MAX : '0)) busy = 1'b1;
    end
  end

  // Disabling clears the whole timebase so a re-enable waits one full step
  // interval before the first brightness change.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre      <= '0;
      pwm_cnt  <= '0;
      fade_cnt <= '0;
      tgt      <= '0;
      period   <= 1'b0;
      led_out  <= '0;
      for (int i = 0; i < CHANNELS; i++) level[i] <= '0;
    end else begin
      tgt <= in_port;
      if (!enable) begin
        pre      <= '0;
        pwm_cnt  <= '0;
        fade_cnt <= '0;
        period   <= 1'b0;
        led_out  <= '0;
        for (int i = 0; i < CHANNELS; i++) level[i] <= '0;
      end else begin
        pre    <= tick ? '0 : (pre + PRE_W'(1));
        period <= wrap;
        if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        if (wrap) fade_cnt <= (fade_cnt == FD_LAST) ? '0 : (fade_cnt + FD_W'(1));
        for (int i = 0; i < CHANNELS; i++) begin
          level[i]   <= level_nxt[i];
          led_out[i] <= (level[i] == MAX) || (level[i] > pwm_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_nios_practica_led_fader.sv
// Bench for nios_practica_led_fader: time-based reference model checked every
// cycle, a duty-cycle vector table, and hand sequences for enable/reset.
module tb_nios_practica_led_fader;

  localparam int CH         = 8;
  localparam int P          = 2;
  localparam int MAXV       = 15;
  localparam int FD         = 2;
  localparam int STP        = 4;
  localparam int PERIOD_CLK = P * (MAXV + 1);
  localparam int STEP_CLK   = PERIOD_CLK * FD;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [CH-1:0] in_port;
  logic [CH-1:0] led_out;
  logic          busy;
  logic          period;

  int vec_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  nios_practica_led_fader #(
    .CHANNELS(CH), .PWM_BITS(4), .PRESCALE(P), .FADE_DIV(FD), .STEP(STP)
  ) dut (
    .clk(clk), .reset(reset), .in_port(in_port), .enable(enable),
    .led_out(led_out), .busy(busy), .period(period)
  );

  // Reference model: everything derived from cycles elapsed since enable.
  int            m_elapsed = 0;
  int            m_pwm     = 0;
  int            m_level [CH];
  logic [CH-1:0] m_tgt    = '0;
  logic [CH-1:0] m_led    = '0;
  logic          m_period = 1'b0;

  initial foreach (m_level[i]) m_level[i] = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_elapsed = 0;
      foreach (m_level[i]) m_level[i] = 0;
      m_tgt    = '0;
      m_led    = '0;
      m_period = 1'b0;
    end else begin
      if (!enable) begin
        m_elapsed = 0;
        foreach (m_level[i]) m_level[i] = 0;
        m_led    = '0;
        m_period = 1'b0;
      end else begin
        m_pwm = (m_elapsed / P) % (MAXV + 1);
        for (int i = 0; i < CH; i++)
          m_led[i] = (m_level[i] == MAXV) || (m_level[i] > m_pwm);
        m_period = ((m_elapsed + 1) % PERIOD_CLK) == 0;
        if (((m_elapsed + 1) % STEP_CLK) == 0) begin
          for (int i = 0; i < CH; i++) begin
            if (m_tgt[i]) m_level[i] = (m_level[i] + STP > MAXV) ? MAXV : m_level[i] + STP;
            else          m_level[i] = (m_level[i] - STP < 0) ? 0 : m_level[i] - STP;
          end
        end
        m_elapsed++;
      end
      m_tgt = in_port;
    end
  end

  function automatic logic model_busy();
    logic b = 1'b0;
    for (int i = 0; i < CH; i++)
      if (m_level[i] != (m_tgt[i] ? MAXV : 0)) b = 1'b1;
    return b;
  endfunction

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic checkOutput();
    compare("led_out", 32'(led_out), 32'(m_led));
    compare("busy", 32'(busy), 32'(model_busy()));
    compare("period", 32'(period), 32'(m_period));
  endtask

  task automatic tickCycle();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [CH-1:0] ip, input logic en,
                               input logic rst, input int cycles);
    in_port = ip;
    enable  = en;
    reset   = rst;
    repeat (cycles) tickCycle();
  endtask

  typedef struct {
    logic [CH-1:0] ip;
    int            steps;
    int            exp_high0;
    logic          exp_busy;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hi;
    int dark;

    // Channel 0 high-clock count over one 32-clk PWM period = 2*level (32 at full).
    tbl[0]  = '{ip: 8'h01, steps: 1, exp_high0: 8,  exp_busy: 1'b1};
    tbl[1]  = '{ip: 8'h01, steps: 1, exp_high0: 16, exp_busy: 1'b1};
    tbl[2]  = '{ip: 8'h01, steps: 1, exp_high0: 24, exp_busy: 1'b1};
    tbl[3]  = '{ip: 8'h01, steps: 1, exp_high0: 32, exp_busy: 1'b0};
    tbl[4]  = '{ip: 8'h01, steps: 1, exp_high0: 32, exp_busy: 1'b0};
    tbl[5]  = '{ip: 8'h00, steps: 1, exp_high0: 22, exp_busy: 1'b1};
    tbl[6]  = '{ip: 8'h00, steps: 1, exp_high0: 14, exp_busy: 1'b1};
    tbl[7]  = '{ip: 8'h00, steps: 1, exp_high0: 6,  exp_busy: 1'b1};
    tbl[8]  = '{ip: 8'h00, steps: 1, exp_high0: 0,  exp_busy: 1'b0};
    tbl[9]  = '{ip: 8'h01, steps: 2, exp_high0: 16, exp_busy: 1'b1};
    tbl[10] = '{ip: 8'h00, steps: 2, exp_high0: 0,  exp_busy: 1'b0};
    tbl[11] = '{ip: 8'h01, steps: 1, exp_high0: 8,  exp_busy: 1'b1};
    tbl[12] = '{ip: 8'h00, steps: 1, exp_high0: 0,  exp_busy: 1'b0};

    in_port = 8'hFF;
    enable  = 1'b1;
    reset   = 1'b1;
    repeat (4) tickCycle();
    compare("reset_led_out", 32'(led_out), 32'h0);
    compare("reset_period", 32'(period), 32'h0);
    compare("reset_busy", 32'(busy), 32'h0);

    applyStimulus(8'hFF, 1'b1, 1'b0, 2);
    compare("busy_after_reset", 32'(busy), 32'h1);

    // Realign the timebase so every table window sits between step edges.
    applyStimulus(8'hFF, 1'b1, 1'b1, 2);
    applyStimulus(8'h00, 1'b1, 1'b0, 40);

    for (int v = 0; v < 13; v++) begin
      applyStimulus(tbl[v].ip, 1'b1, 1'b0, STEP_CLK * tbl[v].steps - 32);
      hi = 0;
      for (int j = 0; j < PERIOD_CLK; j++) begin
        tickCycle();
        hi += int'(led_out[0]);
      end
      compare($sformatf("table%0d_duty", v), 32'(hi), 32'(tbl[v].exp_high0));
      compare($sformatf("table%0d_busy", v), 32'(busy), 32'(tbl[v].exp_busy));
    end

    applyStimulus(8'hA5, 1'b1, 1'b0, STEP_CLK * 5);
    compare("a5_settled_busy", 32'(busy), 32'h0);
    compare("a5_full_on", 32'(led_out), 32'hA5);

    applyStimulus(8'h5A, 1'b1, 1'b0, STEP_CLK * 2);
    applyStimulus(8'h5A, 1'b0, 1'b0, 1);
    compare("disable_dark", 32'(led_out), 32'h0);
    applyStimulus(8'h5A, 1'b0, 1'b0, 10);
    compare("disable_period", 32'(period), 32'h0);

    in_port = 8'h5A;
    enable  = 1'b1;
    dark = 0;
    for (int j = 0; j < STEP_CLK; j++) begin
      tickCycle();
      if (led_out == '0) dark++;
    end
    compare("restart_no_early_step", 32'(dark), 32'(STEP_CLK));
    tickCycle();
    compare("restart_first_step", 32'(led_out), 32'h5A);

    applyStimulus(8'h5A, 1'b1, 1'b0, 100);
    applyStimulus(8'h5A, 1'b1, 1'b1, 1);
    compare("midramp_reset_led", 32'(led_out), 32'h0);
    compare("midramp_reset_period", 32'(period), 32'h0);
    applyStimulus(8'h5A, 1'b1, 1'b0, 1);
    compare("midramp_reset_busy", 32'(busy), 32'h1);

    for (int r = 0; r < 40; r++) begin
      applyStimulus(CH'($urandom()), $urandom_range(0, 9) != 0,
                    $urandom_range(0, 19) == 0, $urandom_range(1, 150));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
